// File: rtl/float_minmax_reduce.sv
// Streaming max/min reduction over frames of class-tagged floating-point words.
// Reports the extreme element, its position, the frame length and whether any NaN was seen.
module float_minmax_reduce #(
  parameter int EXPONENT = 7,
  parameter int MANTISSA = 17,
  parameter int COUNT_W  = 16,
  localparam int W       = EXPONENT + MANTISSA + 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_value,
  output logic [COUNT_W-1:0] out_index,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_nan
);

  localparam int MAG_W = EXPONENT + MANTISSA;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [W-1:0]       r_accValue;
  logic [COUNT_W-1:0] r_accIndex;
  logic [COUNT_W-1:0] r_count;
  logic               r_mode;
  logic               r_nan;

  logic               r_outValid;
  logic [W-1:0]       r_outValue;
  logic [COUNT_W-1:0] r_outIndex;
  logic [COUNT_W-1:0] r_outCount;
  logic               r_outNan;

  logic               w_accept;
  logic               w_isFirst;
  logic               w_elemNan;
  logic               w_accNan;
  logic [W-1:0]       w_elemKey;
  logic [W-1:0]       w_accKey;
  logic               w_better;
  logic               w_replace;
  logic [COUNT_W-1:0] w_nextCount;
  logic [W-1:0]       w_newValue;
  logic [COUNT_W-1:0] w_newIndex;
  logic [COUNT_W-1:0] w_newCount;
  logic               w_newNan;
  logic               w_newMode;

  // Maps a non-NaN word onto an unsigned key whose natural order is the numeric order:
  // a 3-bit tier (-inf, -normal, zero, +normal, +inf) followed by a magnitude that is
  // inverted for negative normals. Both zeros collapse to the same key.
  function automatic logic [W-1:0] orderKey(input logic [W-1:0] v);
    logic [2:0]       tier;
    logic [MAG_W-1:0] mag;
    tier = 3'd2;
    mag  = '0;
    case (v[W-1:W-2])
      2'b01: begin
        tier = v[W-3] ? 3'd1 : 3'd3;
        mag  = v[W-3] ? ~v[MAG_W-1:0] : v[MAG_W-1:0];
      end
      2'b10:   tier = v[W-3] ? 3'd0 : 3'd4;
      default: tier = 3'd2;
    endcase
    return {tier, mag};
  endfunction

  assign w_accept = in_valid && in_ready;
  assign in_ready = !reset_n || !(r_outValid && !out_ready);

  always_comb begin
    w_isFirst   = (r_state == IDLE);
    w_elemNan   = (in_data[W-1:W-2] == 2'b11);
    w_accNan    = (r_accValue[W-1:W-2] == 2'b11);
    w_elemKey   = orderKey(in_data);
    w_accKey    = orderKey(r_accValue);
    w_better    = r_mode ? (w_elemKey < w_accKey) : (w_elemKey > w_accKey);
    w_replace   = !w_elemNan && (w_accNan || w_better);
    w_nextCount = (&r_count) ? r_count : r_count + COUNT_W'(1);

    w_newValue  = r_accValue;
    w_newIndex  = r_accIndex;
    w_newCount  = w_nextCount;
    w_newNan    = r_nan || w_elemNan;
    w_newMode   = r_mode;

    if (w_isFirst) begin
      w_newValue = in_data;
      w_newIndex = '0;
      w_newCount = '0;
      w_newNan   = w_elemNan;
      w_newMode  = in_mode;
    end else if (w_replace) begin
      w_newValue = in_data;
      w_newIndex = w_nextCount;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept && !in_last) w_nextState = ACCUM;
      ACCUM:   if (w_accept && in_last)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_accValue <= '0;
      r_accIndex <= '0;
      r_count    <= '0;
      r_mode     <= 1'b0;
      r_nan      <= 1'b0;
    end else if (w_accept) begin
      r_accValue <= w_newValue;
      r_accIndex <= w_newIndex;
      r_count    <= w_newCount;
      r_mode     <= w_newMode;
      r_nan      <= w_newNan;
    end
  end

  // A finishing beat takes priority over draining, so a same-cycle handshake keeps out_valid high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outValue <= '0;
      r_outIndex <= '0;
      r_outCount <= '0;
      r_outNan   <= 1'b0;
    end else if (w_accept && in_last) begin
      r_outValid <= 1'b1;
      r_outValue <= w_newValue;
      r_outIndex <= w_newIndex;
      r_outCount <= w_newCount;
      r_outNan   <= w_newNan;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_value = r_outValue;
  assign out_index = r_outIndex;
  assign out_count = r_outCount;
  assign out_nan   = r_outNan;

endmodule

// File: tb/tb_float_minmax_reduce.sv
// Directed self-checking bench for float_minmax_reduce with hand-computed results.
// A narrow count width keeps the saturation frames short.
module tb_float_minmax_reduce;

  localparam int E  = 7;
  localparam int M  = 17;
  localparam int CW = 4;
  localparam int W  = E + M + 3;

  logic          clk = 1'b0;
  logic          resetN;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inData;
  logic          inLast;
  logic          inMode;
  logic          outValid;
  logic          outReady;
  logic [W-1:0]  outValue;
  logic [CW-1:0] outIndex;
  logic [CW-1:0] outCount;
  logic          outNan;

  int checks   = 0;
  int failures = 0;

  float_minmax_reduce #(
    .EXPONENT(E),
    .MANTISSA(M),
    .COUNT_W (CW)
  ) dut (
    .clk      (clk),
    .reset_n  (resetN),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  (inData),
    .in_last  (inLast),
    .in_mode  (inMode),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_value(outValue),
    .out_index(outIndex),
    .out_count(outCount),
    .out_nan  (outNan)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fp(input logic [1:0] cls, input logic s, input int e, input int m);
    logic [W-1:0] r;
    r = '0;
    r[W-1:W-2] = cls;
    r[W-3]     = s;
    r[W-4:M]   = e[E-1:0];
    r[M-1:0]   = m[M-1:0];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Presents one beat and holds it until accepted, with a bounded wait on in_ready.
  task automatic applyStimulus(input logic [W-1:0] d, input logic last, input logic mode);
    int guard;
    guard   = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    inMode  = mode;
    while (!inReady && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) checkOutput("readyTimeout", 64'(inReady), 64'(1));
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic expectResult(input string tag, input logic [W-1:0] v, input int idx, input int cnt, input logic nan);
    checkOutput({tag, ".valid"}, 64'(outValid), 64'(1));
    checkOutput({tag, ".value"}, 64'(outValue), 64'(v));
    checkOutput({tag, ".index"}, 64'(outIndex), 64'(idx[CW-1:0]));
    checkOutput({tag, ".count"}, 64'(outCount), 64'(cnt[CW-1:0]));
    checkOutput({tag, ".nan"},   64'(outNan),   64'(nan));
  endtask

  task automatic popResult(input string tag);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, ".drained"}, 64'(outValid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] one, three, negFive, two, four, seven, posZero, negZero;
    logic [W-1:0] negInf, posInf, nanA, nanB, negOne, negThree;
    logic [W-1:0] d;
    one      = fp(2'b01, 1'b0, 63, 0);
    three    = fp(2'b01, 1'b0, 64, 1 << 16);
    negFive  = fp(2'b01, 1'b1, 65, 1 << 15);
    two      = fp(2'b01, 1'b0, 64, 0);
    four     = fp(2'b01, 1'b0, 65, 0);
    seven    = fp(2'b01, 1'b0, 65, 3 << 15);
    posZero  = fp(2'b00, 1'b0, 0, 0);
    negZero  = fp(2'b00, 1'b1, 0, 0);
    negInf   = fp(2'b10, 1'b1, 0, 0);
    posInf   = fp(2'b10, 1'b0, 0, 0);
    nanA     = fp(2'b11, 1'b0, 5, 9);
    nanB     = fp(2'b11, 1'b1, 3, 4);
    negOne   = fp(2'b01, 1'b1, 63, 0);
    negThree = fp(2'b01, 1'b1, 64, 1 << 16);

    resetN   = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inLast   = 1'b0;
    inMode   = 1'b0;
    outReady = 1'b0;
    #1;
    checkOutput("rst.readyEarly", 64'(inReady), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ready", 64'(inReady), 64'(1));
    checkOutput("rst.valid", 64'(outValid), 64'(0));
    checkOutput("rst.value", 64'(outValue), 64'(0));
    checkOutput("rst.index", 64'(outIndex), 64'(0));
    checkOutput("rst.count", 64'(outCount), 64'(0));
    checkOutput("rst.nan",   64'(outNan),   64'(0));
    resetN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst.readyAfter", 64'(inReady), 64'(1));

    applyStimulus(one, 1'b0, 1'b0);
    applyStimulus(three, 1'b0, 1'b0);
    applyStimulus(negFive, 1'b0, 1'b0);
    checkOutput("max.notYet", 64'(outValid), 64'(0));
    applyStimulus(three, 1'b1, 1'b0);
    expectResult("max", three, 1, 3, 1'b0);
    popResult("max");

    applyStimulus(posZero, 1'b0, 1'b1);
    applyStimulus(negZero, 1'b0, 1'b1);
    applyStimulus(two, 1'b0, 1'b1);
    applyStimulus(negInf, 1'b1, 1'b1);
    expectResult("minInf", negInf, 3, 3, 1'b0);
    popResult("minInf");

    applyStimulus(negZero, 1'b0, 1'b0);
    applyStimulus(posZero, 1'b1, 1'b0);
    expectResult("zeroTie", negZero, 0, 1, 1'b0);
    popResult("zeroTie");

    applyStimulus(nanA, 1'b0, 1'b0);
    applyStimulus(seven, 1'b0, 1'b0);
    applyStimulus(nanB, 1'b1, 1'b0);
    expectResult("nanMix", seven, 1, 2, 1'b1);
    popResult("nanMix");

    applyStimulus(nanB, 1'b1, 1'b0);
    expectResult("nanOnly", nanB, 0, 0, 1'b1);
    popResult("nanOnly");

    applyStimulus(two, 1'b0, 1'b0);
    applyStimulus(four, 1'b0, 1'b1);
    applyStimulus(one, 1'b1, 1'b1);
    expectResult("modeLatchMax", four, 1, 2, 1'b0);
    popResult("modeLatchMax");

    applyStimulus(negOne, 1'b0, 1'b1);
    applyStimulus(negThree, 1'b0, 1'b0);
    applyStimulus(posInf, 1'b0, 1'b0);
    applyStimulus(negThree, 1'b1, 1'b0);
    expectResult("minNeg", negThree, 1, 3, 1'b0);
    popResult("minNeg");

    // Back-pressure: a pending result blocks input, then a same-edge drain and reload.
    applyStimulus(one, 1'b1, 1'b0);
    inValid = 1'b1;
    inData  = four;
    inLast  = 1'b1;
    inMode  = 1'b0;
    checkOutput("bp.readyLow", 64'(inReady), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp.holdValid", 64'(outValid), 64'(1));
      checkOutput("bp.holdValue", 64'(outValue), 64'(one));
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp.readyHigh", 64'(inReady), 64'(1));
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b0;
    expectResult("bp.reload", four, 0, 0, 1'b0);
    popResult("bp.reload");

    applyStimulus(one, 1'b0, 1'b0);
    applyStimulus(two, 1'b0, 1'b0);
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midRst.noStale", 64'(outValid), 64'(0));
    applyStimulus(four, 1'b1, 1'b0);
    expectResult("midRst", four, 0, 0, 1'b0);
    popResult("midRst");

    for (int i = 0; i < 18; i++) begin
      d = fp(2'b01, 1'b0, 40 + i, 0);
      applyStimulus(d, i == 17, 1'b0);
    end
    expectResult("satLate", fp(2'b01, 1'b0, 57, 0), 15, 15, 1'b0);
    popResult("satLate");

    for (int i = 0; i < 20; i++) begin
      d = fp(2'b01, 1'b0, (i == 5) ? 90 : 40, 0);
      applyStimulus(d, i == 19, 1'b0);
    end
    expectResult("satEarly", fp(2'b01, 1'b0, 90, 0), 5, 15, 1'b0);
    popResult("satEarly");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_minmax_reduce.md
FLOAT_MINMAX_REDUCE -- requirements
Module: float_minmax_reduce

Interface
REQ-001 SHALL have parameter EXPONENT, default 7, exponent field width.
REQ-002 SHALL have parameter MANTISSA, default 17, mantissa field width.
REQ-003 SHALL have parameter COUNT_W, default 16, width of element index/count.
REQ-004 SHALL define W = EXPONENT+MANTISSA+3; word layout [W-1:W-2] class (00 zero, 01 normal, 10 inf, 11 NaN), [W-3] sign, [W-4:MANTISSA] exponent, [MANTISSA-1:0] mantissa.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  in_data/in_last/in_mode valid.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_data  input  W  float element.
REQ-010 in_last  input  1  final element of frame.
REQ-011 in_mode  input  1  0 = max, 1 = min; sampled on first beat of frame only.
REQ-012 out_valid  output  1  result held.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_value  output  W  selected extreme element, bit-exact copy of input word.
REQ-015 out_index  output  COUNT_W  zero-based position of out_value in frame.
REQ-016 out_count  output  COUNT_W  number of elements in frame minus one.
REQ-017 out_nan  output  1  at least one NaN seen in frame.

Function
REQ-018 Beat accepted iff in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-019 States: IDLE (no frame open), ACCUM (frame open); IDLE->ACCUM on accepted beat with in_last=0; ACCUM->IDLE on accepted beat with in_last=1; IDLE->IDLE on accepted beat with in_last=1 (single-element frame).
REQ-020 First beat of frame: load accumulator with element, index 0, count 0, latch in_mode, nan flag = (class==11).
REQ-021 Subsequent beats: count increments by 1; element replaces accumulator iff strictly better under latched mode; else accumulator unchanged.
REQ-022 Ordering: -inf < -normal (larger magnitude lower) < zero < +normal < +inf; normals ordered by {exponent,mantissa} magnitude with sign applied.
REQ-023 +0 and -0 SHALL compare equal; equal elements never replace (earliest index wins).
REQ-024 NaN elements SHALL never replace a non-NaN accumulator and SHALL set the nan flag; a non-NaN element SHALL always replace a NaN accumulator.
REQ-025 Frame of all NaN: out_value = first element, out_index 0, out_nan 1.
REQ-026 Count saturates at all-ones; elements beyond still compared; out_index of such winners = all-ones.
REQ-027 Latency: on accepted in_last beat, out_valid rises next cycle with final value/index/count/nan including that beat.
REQ-028 Output fields SHALL hold stable while out_valid && !out_ready; out_valid clears the cycle after out_valid && out_ready unless a new result loads the same edge.
REQ-029 Simultaneous out handshake and accepted in_last beat: output register reloads with new result, out_valid stays 1.
REQ-030 Accumulation of a new frame SHALL proceed while a previous result waits, until in_ready drops per REQ-018.
REQ-031 in_mode on non-first beats SHALL be ignored.

Reset
REQ-032 reset_n low at a clock edge: state IDLE, out_valid 0, out_value 0, out_index 0, out_count 0, out_nan 0, accumulator cleared, latched mode 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; next accepted beat starts a new frame.
REQ-034 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-035 Max frame {+1.0, +3.0, -5.0, +3.0(last)}, mode 0 -> out_value +3.0, index 1, count 3, nan 0, one cycle after last beat.
REQ-036 Min frame {+0, -0, +2.0, -inf(last)}, mode 1 -> out_value -inf, index 3; separate max frame {-0, +0(last)} -> out_value -0, index 0.
REQ-037 Frame {NaN, +7.0, NaN(last)}, mode 0 -> out_value +7.0, index 1, nan 1; frame {NaN(last)} -> value NaN word, index 0, nan 1.
REQ-038 Hold out_ready 0 with result pending, stream second frame -> in_ready drops on first cycle of back-pressure; first result stable; assert out_ready with second in_last same cycle -> second result loaded, out_valid continuous.
REQ-039 Drive reset_n low for one cycle after two beats of a frame, then frame {+4.0(last)} -> out_value +4.0, index 0, count 0; no stale result emitted.
REQ-040 Random 10k frames, random EXPONENT/MANTISSA builds (e.g. 5/10, 8/23), back-pressure on both sides -> results match reference model per REQ-021..REQ-026.
